// File: rtl/am2940_pkg.sv
// am2940_pkg: shared encodings for the am2940 command sequencer
package am2940_pkg;

  typedef enum logic [2:0] {
    WRCR   = 3'd0,
    RDCR   = 3'd1,
    RDWC   = 3'd2,
    RDAC   = 3'd3,
    REINIT = 3'd4,
    LDAD   = 3'd5,
    LDWC   = 3'd6,
    ENCT   = 3'd7
  } am2940_instr_e;

  typedef enum logic [2:0] {
    IDLE,
    S_WRCR,
    S_LDAD,
    S_LDWC,
    S_RUN,
    S_END
  } seq_state_e;

  typedef enum logic [1:0] {
    ST_DONE  = 2'd0,
    ST_ABORT = 2'd1,
    ST_TMO   = 2'd2
  } cmpl_status_e;

  localparam int CR_MODE_LSB = 0;
  localparam int CR_MODE_W   = 2;
  localparam int CR_DEC_BIT  = 2;

  // Control-register image for a WRCR: mode in the low bits, direction above it.
  function automatic logic [2:0] cr_bits(input logic [1:0] mode, input logic dec);
    logic [2:0] r;
    r = '0;
    r[CR_MODE_LSB +: CR_MODE_W] = mode;
    r[CR_DEC_BIT] = dec;
    return r;
  endfunction

endpackage

// File: rtl/am2940_cmd_seq_if.sv
// am2940_cmd_seq_if: transfer-command handshake into the sequencer
interface am2940_cmd_seq_if #(
  parameter int AW = 8
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_count;
  logic [1:0]    cmd_mode;
  logic          cmd_dec;

  modport master (output cmd_valid, cmd_addr, cmd_count, cmd_mode, cmd_dec, input cmd_ready);
  modport slave  (input cmd_valid, cmd_addr, cmd_count, cmd_mode, cmd_dec, output cmd_ready);
endinterface

// File: rtl/am2940_tmo_cnt.sv
// am2940_tmo_cnt: saturating idle timer; expired flags the cycle it reaches all-ones
module am2940_tmo_cnt #(
  parameter int TMO_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TMO_W-1:0] cnt, cnt_n;

  // Clear dominates; counting stops at all-ones so a stalled caller keeps seeing expiry.
  always_comb cnt_n = clr ? '0 : (en && !(&cnt)) ? cnt + 1'b1 : cnt;

  assign expired = &cnt_n;

  // Timer register.
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= cnt_n;
endmodule

// File: rtl/am2940_cmd_seq.sv
// am2940_cmd_seq: turns one transfer command into the am2940 WRCR/LDAD/LDWC/ENCT stream
module am2940_cmd_seq
  import am2940_pkg::*;
#(
  parameter int   AW      = 8,
  parameter int   TMO_W   = 12,
  parameter logic CIN_ACT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  am2940_cmd_seq_if.slave      cmd,
  input  logic                 xfer_stb,
  input  logic                 abort,
  input  logic                 done,
  output logic [2:0]           instr,
  output logic [AW-1:0]        datain,
  output logic                 cina,
  output logic                 cinw,
  output logic                 busy,
  output logic                 cmpl,
  output logic [1:0]           cmpl_status,
  output logic [AW-1:0]        step_cnt
);
  seq_state_e    state, state_n;
  am2940_instr_e instr_n;
  logic [AW-1:0] datain_n, step_n, addr_q, count_q;
  logic [1:0]    status_n;
  logic          cin_n, cmpl_n, ready, accept, tmo;

  assign cmd.cmd_ready = ready;
  assign accept = cmd.cmd_valid && ready;

  am2940_tmo_cnt #(.TMO_W(TMO_W)) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr((state != S_RUN) || xfer_stb),
    .en(state == S_RUN),
    .expired(tmo)
  );

  // Latch the command so the later load states can replay address and count.
  always_ff @(posedge clk)
    if (accept) begin
      addr_q  <= cmd.cmd_addr;
      count_q <= cmd.cmd_count;
    end

  // Next state plus the values every registered output takes in that state.
  always_comb begin
    state_n  = state;
    instr_n  = RDCR;
    datain_n = '0;
    cin_n    = ~CIN_ACT;
    cmpl_n   = 1'b0;
    status_n = cmpl_status;
    step_n   = step_cnt;
    unique case (state)
      IDLE:
        if (accept) begin
          state_n  = S_WRCR;
          instr_n  = WRCR;
          datain_n = AW'(cr_bits(cmd.cmd_mode, cmd.cmd_dec));
          step_n   = '0;
        end
      S_WRCR: begin
        state_n  = S_LDAD;
        instr_n  = LDAD;
        datain_n = addr_q;
      end
      S_LDAD: begin
        state_n  = S_LDWC;
        instr_n  = LDWC;
        datain_n = count_q;
      end
      S_LDWC: begin
        state_n = S_RUN;
        instr_n = ENCT;
      end
      S_RUN:
        if (done || abort || tmo) begin
          state_n  = S_END;
          cmpl_n   = 1'b1;
          status_n = done ? ST_DONE : abort ? ST_ABORT : ST_TMO;
        end else begin
          instr_n = ENCT;
          cin_n   = xfer_stb ? CIN_ACT : ~CIN_ACT;
          step_n  = xfer_stb ? step_cnt + 1'b1 : step_cnt;
        end
      S_END: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // All outputs are registered copies of the next-state decode.
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      instr       <= RDCR;
      datain      <= '0;
      cina        <= ~CIN_ACT;
      cinw        <= ~CIN_ACT;
      cmpl        <= 1'b0;
      cmpl_status <= '0;
      step_cnt    <= '0;
      ready       <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      instr       <= instr_n;
      datain      <= datain_n;
      cina        <= cin_n;
      cinw        <= cin_n;
      cmpl        <= cmpl_n;
      cmpl_status <= status_n;
      step_cnt    <= step_n;
      ready       <= state_n == IDLE;
      busy        <= state_n != IDLE;
    end
endmodule
